// File: rtl/rtc_time_counter.sv
// rtc_time_counter: divides a synchronous 32.768 kHz tick into seconds and keeps hh:mm:ss time-of-day with a load port.
// Latency: one clkin1 cycle from tick edge or load to outputs. Backpressure: none. Optional alarm via RTC_TIME_COUNTER_ALARM_EN.
module rtc_time_counter #(
  parameter int TICKS_PER_SEC = 32768,
  parameter int SUB_W         = 15
) (
  input  logic       clkin1,
  input  logic       pll_rst,
  input  logic       tick_in,
  input  logic       load_valid,
  input  logic [4:0] load_hh,
  input  logic [5:0] load_mm,
  input  logic [5:0] load_ss,
  input  logic [4:0] alarm_hh,
  input  logic [5:0] alarm_mm,
  input  logic [5:0] alarm_ss,
  output logic       sec_pulse,
  output logic [4:0] hh,
  output logic [5:0] mm,
  output logic [5:0] ss,
  output logic       time_valid,
  output logic       load_err,
  output logic       alarm_hit
);

  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(TICKS_PER_SEC - 1);

  logic             tick_d_q, tick_d_d;
  logic [SUB_W-1:0] sub_cnt_q, sub_cnt_d;
  logic [4:0]       hh_q, hh_d;
  logic [5:0]       mm_q, mm_d;
  logic [5:0]       ss_q, ss_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             time_valid_q, time_valid_d;
  logic             load_err_q, load_err_d;
  logic             tick_edge;
  logic             load_ok;

  always_comb begin
    tick_edge    = tick_in & ~tick_d_q;
    load_ok      = (load_hh <= 5'd23) && (load_mm <= 6'd59) && (load_ss <= 6'd59);
    tick_d_d     = tick_in;
    sub_cnt_d    = sub_cnt_q;
    hh_d         = hh_q;
    mm_d         = mm_q;
    ss_d         = ss_q;
    sec_pulse_d  = 1'b0;
    time_valid_d = time_valid_q;
    load_err_d   = 1'b0;

    if (load_valid && load_ok) begin
      // A valid load swallows any coincident edge and restarts the second.
      hh_d         = load_hh;
      mm_d         = load_mm;
      ss_d         = load_ss;
      sub_cnt_d    = '0;
      time_valid_d = 1'b1;
    end else begin
      load_err_d = load_valid;
      if (tick_edge) begin
        if (sub_cnt_q == SUB_MAX) begin
          sub_cnt_d   = '0;
          sec_pulse_d = 1'b1;
          if (ss_q == 6'd59) begin
            ss_d = 6'd0;
            if (mm_q == 6'd59) begin
              mm_d = 6'd0;
              hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
            end else begin
              mm_d = mm_q + 6'd1;
            end
          end else begin
            ss_d = ss_q + 6'd1;
          end
        end else begin
          sub_cnt_d = sub_cnt_q + SUB_W'(1);
        end
      end
    end
  end

  // tick_d resets high so a wave already high at reset release is not an edge.
  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) begin
      tick_d_q     <= 1'b1;
      sub_cnt_q    <= '0;
      hh_q         <= 5'd0;
      mm_q         <= 6'd0;
      ss_q         <= 6'd0;
      sec_pulse_q  <= 1'b0;
      time_valid_q <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      tick_d_q     <= tick_d_d;
      sub_cnt_q    <= sub_cnt_d;
      hh_q         <= hh_d;
      mm_q         <= mm_d;
      ss_q         <= ss_d;
      sec_pulse_q  <= sec_pulse_d;
      time_valid_q <= time_valid_d;
      load_err_q   <= load_err_d;
    end
  end

`ifdef RTC_TIME_COUNTER_ALARM_EN
  logic alarm_hit_q, alarm_hit_d;

  // Compare only right after a counted second, so a load onto the alarm time stays silent.
  always_comb begin
    alarm_hit_d = sec_pulse_q && time_valid_q &&
                  ({hh_q, mm_q, ss_q} == {alarm_hh, alarm_mm, alarm_ss});
  end

  always_ff @(posedge clkin1 or negedge pll_rst) begin
    if (!pll_rst) alarm_hit_q <= 1'b0;
    else          alarm_hit_q <= alarm_hit_d;
  end

  assign alarm_hit = alarm_hit_q;
`else
  logic unused_alarm;
  assign unused_alarm = ^{alarm_hh, alarm_mm, alarm_ss};
  assign alarm_hit    = 1'b0;
`endif

  assign sec_pulse  = sec_pulse_q;
  assign hh         = hh_q;
  assign mm         = mm_q;
  assign ss         = ss_q;
  assign time_valid = time_valid_q;
  assign load_err   = load_err_q;

endmodule

// File: tb/tb_rtc_time_counter.sv
// Directed bench for rtc_time_counter with TICKS_PER_SEC=4; inputs driven and outputs sampled on the falling edge.
module tb_rtc_time_counter;

`ifdef RTC_TIME_COUNTER_ALARM_EN
  localparam int ALARM_ON = 1;
`else
  localparam int ALARM_ON = 0;
`endif

  logic       clkin1 = 1'b0;
  logic       pll_rst, tick_in, load_valid;
  logic [4:0] load_hh, alarm_hh;
  logic [5:0] load_mm, load_ss, alarm_mm, alarm_ss;
  logic       sec_pulse, time_valid, load_err, alarm_hit;
  logic [4:0] hh;
  logic [5:0] mm, ss;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;
  int alarms   = 0;
  int base;
  logic p;

  always #5 clkin1 = ~clkin1;

  rtc_time_counter #(.TICKS_PER_SEC(4), .SUB_W(2)) dut (
    .clkin1(clkin1), .pll_rst(pll_rst), .tick_in(tick_in),
    .load_valid(load_valid), .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_ss(alarm_ss),
    .sec_pulse(sec_pulse), .hh(hh), .mm(mm), .ss(ss),
    .time_valid(time_valid), .load_err(load_err), .alarm_hit(alarm_hit)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    chk(tag, {15'd0, hh, mm, ss}, {15'd0, h, m, s});
  endtask

  // One rising edge: returns sec_pulse as seen the cycle after the edge.
  task automatic tick(output logic pe);
    tick_in = 1'b1;
    @(negedge clkin1);
    pe = sec_pulse;
    pulses += int'(sec_pulse);
    alarms += int'(alarm_hit);
    tick_in = 1'b0;
    @(negedge clkin1);
    pulses += int'(sec_pulse);
    alarms += int'(alarm_hit);
  endtask

  task automatic do_load(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    load_valid = 1'b1;
    load_hh = h; load_mm = m; load_ss = s;
    @(negedge clkin1);
    load_valid = 1'b0;
  endtask

  initial begin
    pll_rst = 1'b0; tick_in = 1'b1; load_valid = 1'b0;
    load_hh = 5'd0; load_mm = 6'd0; load_ss = 6'd0;
    alarm_hh = 5'd0; alarm_mm = 6'd0; alarm_ss = 6'd2;

    // Reset, then a wave held high must not count as an edge.
    repeat (2) @(negedge clkin1);
    chk_time("rst_time", 5'd0, 6'd0, 6'd0);
    chk("rst_valid", time_valid, 0);
    pll_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clkin1);
      chk("hi_no_pulse", sec_pulse, 0);
    end
    chk_time("hi_time", 5'd0, 6'd0, 6'd0);
    chk("hi_flags", {time_valid, load_err, alarm_hit}, 0);

    // First second: pulse exactly after the 4th edge, one cycle wide.
    tick_in = 1'b0;
    @(negedge clkin1);
    base = pulses;
    for (int i = 0; i < 3; i++) begin
      tick(p);
      chk("sec1_early", p, 0);
    end
    tick(p);
    chk("sec1_pulse", p, 1);
    chk("sec1_count", pulses - base, 1);
    chk_time("sec1_time", 5'd0, 6'd0, 6'd1);
    chk("sec1_tv", time_valid, 0);

    // Invalid load is flagged and changes nothing.
    do_load(5'd12, 6'd60, 6'd0);
    chk("inv_err", load_err, 1);
    chk_time("inv_time", 5'd0, 6'd0, 6'd1);
    chk("inv_tv", time_valid, 0);
    @(negedge clkin1);
    chk("inv_err_1cyc", load_err, 0);

    // Full-day wrap.
    do_load(5'd23, 6'd59, 6'd59);
    chk_time("wrap_load", 5'd23, 6'd59, 6'd59);
    chk("wrap_tv", time_valid, 1);
    chk("wrap_no_err", load_err, 0);
    base = pulses;
    for (int i = 0; i < 4; i++) tick(p);
    chk("wrap_pulse", p, 1);
    chk("wrap_count", pulses - base, 1);
    chk_time("wrap_time", 5'd0, 6'd0, 6'd0);

    // Valid load on the 4th edge wins; next second restarts from zero.
    for (int i = 0; i < 3; i++) tick(p);
    tick_in = 1'b1; load_valid = 1'b1;
    load_hh = 5'd5; load_mm = 6'd6; load_ss = 6'd7;
    @(negedge clkin1);
    chk("coll_no_pulse", sec_pulse, 0);
    chk_time("coll_time", 5'd5, 6'd6, 6'd7);
    tick_in = 1'b0; load_valid = 1'b0;
    @(negedge clkin1);
    base = pulses;
    for (int i = 0; i < 3; i++) tick(p);
    chk("coll_3_edges", pulses - base, 0);
    tick(p);
    chk("coll_pulse", p, 1);
    chk_time("coll_next", 5'd5, 6'd6, 6'd8);

    // Invalid load on a rollover edge: error plus normal count.
    for (int i = 0; i < 3; i++) tick(p);
    tick_in = 1'b1; load_valid = 1'b1;
    load_hh = 5'd24; load_mm = 6'd0; load_ss = 6'd0;
    @(negedge clkin1);
    chk("invroll_err", load_err, 1);
    chk("invroll_pulse", sec_pulse, 1);
    chk_time("invroll_time", 5'd5, 6'd6, 6'd9);
    tick_in = 1'b0; load_valid = 1'b0;
    @(negedge clkin1);

    // Load held over several edges keeps the sub-second count at zero.
    load_valid = 1'b1;
    load_hh = 5'd0; load_mm = 6'd0; load_ss = 6'd58;
    base = pulses;
    for (int i = 0; i < 8; i++) begin
      tick_in = ~tick_in;
      @(negedge clkin1);
      pulses += int'(sec_pulse);
    end
    load_valid = 1'b0;
    chk("hold_no_pulse", pulses - base, 0);
    chk_time("hold_time", 5'd0, 6'd0, 6'd58);
    for (int i = 0; i < 4; i++) tick(p);
    chk("hold_release", p, 1);
    chk_time("ss59", 5'd0, 6'd0, 6'd59);
    for (int i = 0; i < 4; i++) tick(p);
    chk_time("mm_carry", 5'd0, 6'd1, 6'd0);

    do_load(5'd0, 6'd59, 6'd59);
    for (int i = 0; i < 4; i++) tick(p);
    chk_time("hh_carry", 5'd1, 6'd0, 6'd0);

    // Alarm at 00:00:02: a load onto it is silent; counting into it fires once.
    do_load(5'd0, 6'd0, 6'd2);
    repeat (2) begin
      @(negedge clkin1);
      chk("alarm_load_silent", alarm_hit, 0);
    end
    chk("alarm_none_yet", alarms, 0);
    do_load(5'd0, 6'd0, 6'd0);
    for (int i = 0; i < 4; i++) tick(p);
    chk("alarm_not_sec1", alarm_hit, 0);
    for (int i = 0; i < 4; i++) tick(p);
    chk("alarm_sec2_pulse", p, 1);
    chk("alarm_hit_cycle", alarm_hit, ALARM_ON);
    @(negedge clkin1);
    chk("alarm_hit_1cyc", alarm_hit, 0);
    chk("alarm_total", alarms, ALARM_ON);
    chk_time("alarm_time", 5'd0, 6'd0, 6'd2);

    // Asynchronous reset mid-operation clears state without a clock edge.
    #2 pll_rst = 1'b0;
    #1;
    chk_time("arst_time", 5'd0, 6'd0, 6'd0);
    chk("arst_tv", time_valid, 0);
    @(negedge clkin1);
    pll_rst = 1'b1;
    @(negedge clkin1);
    for (int i = 0; i < 4; i++) tick(p);
    chk("post_rst_pulse", p, 1);
    chk_time("post_rst_time", 5'd0, 6'd0, 6'd1);
    chk("post_rst_tv", time_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
